// File: rtl/eth_frame_gen.sv
// Synthetic Ethernet frame source on a 64-bit AXI-Stream master.
// Each frame: fixed L2 header, 32-bit sequence number, then payload byte n = n[7:0].
module eth_frame_gen #(
  parameter logic [47:0] DST_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_02,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk156,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] frame_len,
  input  logic [7:0]  ipg_cycles,
  input  logic [31:0] frame_count,
  input  logic        m_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_IPG, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  ipg_q, ipg_d;
  logic [7:0]  ipg_cnt_q, ipg_cnt_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] sent_q, sent_d;
  logic        tvalid_q, tvalid_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        hs;

  function automatic logic [10:0] clamp_len(input logic [15:0] l);
    if (l < 16'd60)        return 11'd60;
    else if (l > 16'd1514) return 11'd1514;
    else                   return l[10:0];
  endfunction

  function automatic logic [63:0] beat_bytes(input logic [7:0] beat, input logic [31:0] seq);
    logic [143:0] hdr;
    logic [143:0] sh;
    logic [63:0]  d;
    logic [7:0]   b;
    int           k;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
    d   = '0;
    for (int i = 0; i < 8; i++) begin
      k = 8 * int'(beat) + i;
      if (k < 18) begin
        sh = hdr >> (8 * (17 - k));
        b  = sh[7:0];
      end else begin
        b = k[7:0];
      end
      d = d | ({56'd0, b} << (8 * i));
    end
    return d;
  endfunction

  function automatic logic [7:0] keep_for(input logic [10:0] len, input logic last);
    if (!last || len[2:0] == 3'd0) return 8'hFF;
    return (8'd1 << len[2:0]) - 8'd1;
  endfunction

  assign hs = tvalid_q & m_axis_tready;

  always_ff @(posedge clk156) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      ipg_q     <= '0;
      ipg_cnt_q <= '0;
      beat_q    <= '0;
      seq_q     <= '0;
      sent_q    <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ipg_q     <= ipg_d;
      ipg_cnt_q <= ipg_cnt_d;
      beat_q    <= beat_d;
      seq_q     <= seq_d;
      sent_q    <= sent_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ipg_d     = ipg_q;
    ipg_cnt_d = ipg_cnt_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    sent_d    = sent_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SEND;
          len_d   = clamp_len(frame_len);
          ipg_d   = ipg_cycles;
          beat_d  = '0;
        end
      end
      S_SEND: begin
        if (hs && tlast_q) begin
          sent_d = sent_q + 32'd1;
          seq_d  = seq_q + 32'd1;
          beat_d = '0;
          if (frame_count != 32'd0 && sent_d == frame_count) begin
            state_d = S_DONE;
          end else if (ipg_q != 8'd0) begin
            state_d   = S_IPG;
            ipg_cnt_d = ipg_q - 8'd1;
          end else if (enable) begin
            len_d = clamp_len(frame_len);
            ipg_d = ipg_cycles;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hs) begin
          beat_d = beat_q + 8'd1;
        end
      end
      S_IPG: begin
        // Counter was loaded with g-1 so exactly g idle cycles separate frames.
        if (ipg_cnt_q == 8'd0) begin
          if (enable) begin
            state_d = S_SEND;
            len_d   = clamp_len(frame_len);
            ipg_d   = ipg_cycles;
            beat_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ipg_cnt_d = ipg_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
          sent_d  = '0;
          seq_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded with the beat belonging to the next state,
  // so a stalled beat recomputes to identical values.
  always_comb begin
    tvalid_d = 1'b0;
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;
    busy_d   = (state_d == S_SEND) || (state_d == S_IPG);
    done_d   = (state_d == S_DONE);
    if (state_d == S_SEND) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_bytes(beat_d, seq_d);
      tlast_d  = (beat_d == 8'((len_d - 11'd1) >> 3));
      tkeep_d  = keep_for(len_d, tlast_d);
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = 1'b0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_sent   = sent_q;

endmodule
